// File: rtl/sump_uart_core.sv
// Serial transport for the SUMP command link: shared baud prescaler,
// 8N1 command receiver (1- or 5-byte commands) and 32-bit word transmitter.
module sump_uart_core #(
    parameter int FREQ  = 100000000,
    parameter int SCALE = 28,
    parameter int RATE  = 115200
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  speed,
    input  logic        rx,
    output logic        tx,
    output logic [7:0]  op,
    output logic [31:0] data,
    output logic        execute,
    input  logic        write,
    input  logic [31:0] wrdata,
    input  logic [3:0]  disabledGroups,
    input  logic        id,
    input  logic        xon,
    input  logic        xoff,
    output logic        busy
);
    // BITLENGTH must come out >= 4 so the half-bit start sample lands inside the start bit.
    localparam int BITLENGTH = (FREQ / SCALE) / RATE;
    localparam int TW        = $clog2(BITLENGTH + 1);
    localparam int PW        = $clog2(6 * SCALE + 1);

    localparam logic [TW-1:0] BIT_LAST  = TW'(BITLENGTH - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(BITLENGTH / 2 - 1);
    localparam logic [31:0]   ID_WORD   = 32'h534C4131;

    logic [PW-1:0] pre_cnt_q, pre_cnt_d;
    logic [PW-1:0] pre_top_q, pre_top_d;
    logic [PW-1:0] speed_top;
    logic          tick;

    always_comb begin
        case (speed)
            2'b00:   speed_top = PW'(SCALE - 1);
            2'b01:   speed_top = PW'(2 * SCALE - 1);
            2'b10:   speed_top = PW'(3 * SCALE - 1);
            default: speed_top = PW'(6 * SCALE - 1);
        endcase
    end

    // The period is reloaded only at wrap, so a speed change never truncates a tick.
    always_comb begin
        tick      = (pre_cnt_q == pre_top_q);
        pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;
        pre_top_d = tick ? speed_top : pre_top_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            pre_cnt_q <= '0;
            pre_top_q <= speed_top;
        end else begin
            pre_cnt_q <= pre_cnt_d;
            pre_top_q <= pre_top_d;
        end
    end

    logic rx_meta_q, rx_sync_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_ERR} rx_state_e;

    rx_state_e     rx_state_q, rx_state_d;
    logic [TW-1:0] rx_tcnt_q, rx_tcnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic [2:0]    rx_nbyte_q, rx_nbyte_d;
    logic [7:0]    op_pend_q, op_pend_d;
    logic [31:0]   data_pend_q, data_pend_d;
    logic [7:0]    op_q, op_d;
    logic [31:0]   data_q, data_d;
    logic          execute_q, execute_d;

    // NOTE: every signal gets its default first so no path through the case can infer a latch.
    always_comb begin
        rx_state_d  = rx_state_q;
        rx_tcnt_d   = rx_tcnt_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_nbyte_d  = rx_nbyte_q;
        op_pend_d   = op_pend_q;
        data_pend_d = data_pend_q;
        op_d        = op_q;
        data_d      = data_q;
        execute_d   = 1'b0;

        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_sync_q) begin
                    rx_state_d = RX_START;
                    rx_tcnt_d  = '0;
                end
            end
            RX_START: begin
                if (tick) begin
                    if (rx_tcnt_q == HALF_LAST) begin
                        rx_tcnt_d  = '0;
                        rx_bit_d   = 3'd0;
                        rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_tcnt_d = rx_tcnt_q + 1'b1;
                    end
                end
            end
            RX_DATA: begin
                if (tick) begin
                    if (rx_tcnt_q == BIT_LAST) begin
                        rx_tcnt_d  = '0;
                        rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                        rx_bit_d   = rx_bit_q + 1'b1;
                        if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                    end else begin
                        rx_tcnt_d = rx_tcnt_q + 1'b1;
                    end
                end
            end
            RX_STOP: begin
                if (tick) begin
                    if (rx_tcnt_q == BIT_LAST) begin
                        if (!rx_sync_q) begin
                            // Framing error: drop whatever part of a command was collected.
                            rx_state_d = RX_ERR;
                            rx_nbyte_d = 3'd0;
                        end else begin
                            rx_state_d = RX_IDLE;
                            if (rx_nbyte_q == 3'd0) begin
                                op_pend_d = rx_shift_q;
                                if (!rx_shift_q[7]) begin
                                    op_d      = rx_shift_q;
                                    data_d    = 32'd0;
                                    execute_d = 1'b1;
                                end else begin
                                    rx_nbyte_d = 3'd1;
                                end
                            end else begin
                                data_pend_d = {rx_shift_q, data_pend_q[31:8]};
                                if (rx_nbyte_q == 3'd4) begin
                                    op_d       = op_pend_q;
                                    data_d     = {rx_shift_q, data_pend_q[31:8]};
                                    execute_d  = 1'b1;
                                    rx_nbyte_d = 3'd0;
                                end else begin
                                    rx_nbyte_d = rx_nbyte_q + 1'b1;
                                end
                            end
                        end
                    end else begin
                        rx_tcnt_d = rx_tcnt_q + 1'b1;
                    end
                end
            end
            RX_ERR: begin
                if (rx_sync_q) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_state_q  <= RX_IDLE;
            rx_tcnt_q   <= '0;
            rx_bit_q    <= 3'd0;
            rx_shift_q  <= 8'd0;
            rx_nbyte_q  <= 3'd0;
            op_pend_q   <= 8'd0;
            data_pend_q <= 32'd0;
            op_q        <= 8'd0;
            data_q      <= 32'd0;
            execute_q   <= 1'b0;
        end else begin
            rx_state_q  <= rx_state_d;
            rx_tcnt_q   <= rx_tcnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            rx_nbyte_q  <= rx_nbyte_d;
            op_pend_q   <= op_pend_d;
            data_pend_q <= data_pend_d;
            op_q        <= op_d;
            data_q      <= data_d;
            execute_q   <= execute_d;
        end
    end

    assign op      = op_q;
    assign data    = data_q;
    assign execute = execute_q;

    typedef enum logic [2:0] {TX_IDLE, TX_NEXT, TX_START, TX_DATA, TX_STOP} tx_state_e;

    tx_state_e     tx_state_q, tx_state_d;
    logic          tx_q, tx_d;
    logic [TW-1:0] tx_tcnt_q, tx_tcnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic [31:0]   tx_word_q, tx_word_d;
    logic [3:0]    tx_rem_q, tx_rem_d;
    logic          paused_q, paused_d;
    logic [1:0]    sel_idx;
    logic [7:0]    sel_byte;
    logic          launch;

    // tx_rem_q marks bytes still owed; the lowest one goes next, so skipping costs no time.
    always_comb begin
        sel_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (tx_rem_q[i]) sel_idx = 2'(i);
        end
        sel_byte = tx_word_q[8*sel_idx +: 8];
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_d       = tx_q;
        tx_tcnt_d  = tx_tcnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_word_d  = tx_word_q;
        tx_rem_d   = tx_rem_q;
        launch     = 1'b0;
        paused_d   = xoff ? 1'b1 : (xon ? 1'b0 : paused_q);

        case (tx_state_q)
            TX_IDLE: begin
                if (write) begin
                    tx_word_d  = wrdata;
                    tx_rem_d   = ~disabledGroups;
                    tx_state_d = TX_NEXT;
                end else if (id) begin
                    tx_word_d  = ID_WORD;
                    tx_rem_d   = 4'hF;
                    tx_state_d = TX_NEXT;
                end
            end
            TX_NEXT: begin
                if (tx_rem_q == 4'd0) tx_state_d = TX_IDLE;
                else if (tick && !paused_q) launch = 1'b1;
            end
            TX_START: begin
                if (tick) begin
                    if (tx_tcnt_q == BIT_LAST) begin
                        tx_d       = tx_shift_q[0];
                        tx_tcnt_d  = '0;
                        tx_bit_d   = 3'd0;
                        tx_state_d = TX_DATA;
                    end else begin
                        tx_tcnt_d = tx_tcnt_q + 1'b1;
                    end
                end
            end
            TX_DATA: begin
                if (tick) begin
                    if (tx_tcnt_q == BIT_LAST) begin
                        tx_tcnt_d = '0;
                        if (tx_bit_q == 3'd7) begin
                            tx_d       = 1'b1;
                            tx_state_d = TX_STOP;
                        end else begin
                            tx_shift_d = {1'b0, tx_shift_q[7:1]};
                            tx_d       = tx_shift_q[1];
                            tx_bit_d   = tx_bit_q + 1'b1;
                        end
                    end else begin
                        tx_tcnt_d = tx_tcnt_q + 1'b1;
                    end
                end
            end
            TX_STOP: begin
                if (tick) begin
                    if (tx_tcnt_q == BIT_LAST) begin
                        if (tx_rem_q == 4'd0) tx_state_d = TX_IDLE;
                        else if (!paused_q)   launch     = 1'b1;
                        else                  tx_state_d = TX_NEXT;
                    end else begin
                        tx_tcnt_d = tx_tcnt_q + 1'b1;
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase

        if (launch) begin
            tx_state_d = TX_START;
            tx_d       = 1'b0;
            tx_tcnt_d  = '0;
            tx_shift_d = sel_byte;
            tx_rem_d   = tx_rem_q & ~(4'b0001 << sel_idx);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tx_state_q <= TX_IDLE;
            tx_q       <= 1'b1;
            tx_tcnt_q  <= '0;
            tx_bit_q   <= 3'd0;
            tx_shift_q <= 8'd0;
            tx_word_q  <= 32'd0;
            tx_rem_q   <= 4'd0;
            paused_q   <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_q       <= tx_d;
            tx_tcnt_q  <= tx_tcnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_word_q  <= tx_word_d;
            tx_rem_q   <= tx_rem_d;
            paused_q   <= paused_d;
        end
    end

    assign tx   = tx_q;
    assign busy = (tx_state_q != TX_IDLE);

endmodule

// File: tb/tb_sump_uart_core.sv
// Directed bench for sump_uart_core at FREQ=800, SCALE=2, RATE=50 (16 clocks per bit at speed 00).
module tb_sump_uart_core;
    localparam int BITCLK = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  speed = 2'b00;
    logic        rx = 1'b1;
    logic        tx;
    logic [7:0]  op;
    logic [31:0] data;
    logic        execute;
    logic        write = 1'b0;
    logic [31:0] wrdata = 32'd0;
    logic [3:0]  disabledGroups = 4'd0;
    logic        id = 1'b0;
    logic        xon = 1'b0;
    logic        xoff = 1'b0;
    logic        busy;

    always #5 clock = ~clock;

    sump_uart_core #(.FREQ(800), .SCALE(2), .RATE(50)) dut (
        .clock(clock), .reset(reset), .speed(speed), .rx(rx), .tx(tx),
        .op(op), .data(data), .execute(execute), .write(write), .wrdata(wrdata),
        .disabledGroups(disabledGroups), .id(id), .xon(xon), .xoff(xoff), .busy(busy)
    );

    int n_pass  = 0;
    int n_total = 0;
    int exec_cnt = 0;

    always @(negedge clock) if (execute === 1'b1) exec_cnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic tick_n(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic uart_send(input logic [7:0] b, input logic stop_bit);
        @(negedge clock);
        rx = 1'b0;
        tick_n(BITCLK);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick_n(BITCLK);
        end
        rx = stop_bit;
        tick_n(BITCLK);
        rx = 1'b1;
    endtask

    // Waits (bounded) for a start bit, samples mid-bit, returns at mid stop bit.
    task automatic uart_recv(input int mult, input int budget, output logic [7:0] b, output logic ok);
        int bc;
        bc = BITCLK * mult;
        ok = 1'b0;
        b  = 8'd0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (tx === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) return;
        tick_n(bc / 2);
        if (tx !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick_n(bc);
            b[i] = tx;
        end
        tick_n(bc);
        if (tx !== 1'b1) ok = 1'b0;
    endtask

    typedef struct {
        logic [1:0] spd;
        int         latency;
        int         width;
    } spd_vec_t;

    typedef struct {
        logic        is_id;
        logic [31:0] word;
        logic [3:0]  dis;
        int          n;
        logic [31:0] exp;
        logic        poke;
    } tx_vec_t;

    typedef struct {
        int          n;
        logic [39:0] bytes;
        logic [7:0]  op;
        logic [31:0] data;
    } rx_vec_t;

    spd_vec_t sv[4];
    tx_vec_t  tv[4];
    rx_vec_t  rv[4];

    logic [7:0] rb;
    logic       rok;
    int         cnt;
    int         base;
    logic [7:0] prev_op;

    initial begin
        sv[0] = '{2'b00, 1, 144};
        sv[1] = '{2'b01, 3, 288};
        sv[2] = '{2'b10, 5, 432};
        sv[3] = '{2'b11, 11, 864};

        tv[0] = '{1'b0, 32'hA1B2C3D4, 4'b0000, 4, 32'hA1B2C3D4, 1'b0};
        tv[1] = '{1'b0, 32'hA1B2C3D4, 4'b0101, 2, 32'h0000A1C3, 1'b0};
        tv[2] = '{1'b1, 32'h00000000, 4'b0000, 4, 32'h534C4131, 1'b1};
        tv[3] = '{1'b0, 32'h00FF8001, 4'b1000, 3, 32'h00FF8001, 1'b0};

        rv[0] = '{1, 40'h00000000_01, 8'h01, 32'h00000000};
        rv[1] = '{5, 40'h12345678_80, 8'h80, 32'h12345678};
        rv[2] = '{1, 40'h00000000_11, 8'h11, 32'h00000000};
        rv[3] = '{5, 40'hDDCCBBAA_FF, 8'hFF, 32'hDDCCBBAA};

        // Reset state
        tick_n(4);
        reset = 1'b0;
        tick_n(1);
        check("reset tx", 32'(tx), 32'd1);
        check("reset busy", 32'(busy), 32'd0);
        check("reset op", 32'(op), 32'd0);
        check("reset data", data, 32'd0);
        check("reset execute", 32'(execute), 32'd0);

        // Prescaler: tick period per speed, seen as start latency and frame width
        for (int v = 0; v < 4; v++) begin
            @(negedge clock);
            reset = 1'b1;
            speed = sv[v].spd;
            tick_n(3);
            @(negedge clock);
            reset = 1'b0;
            write = 1'b1;
            wrdata = 32'h00000000;
            disabledGroups = 4'b1110;
            @(negedge clock);
            write = 1'b0;
            cnt = 0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clock);
                cnt++;
                if (tx === 1'b0) break;
            end
            check($sformatf("speed%0d start latency", v), 32'(cnt), 32'(sv[v].latency));
            cnt = 1;
            for (int i = 0; i < 2000; i++) begin
                @(negedge clock);
                if (tx !== 1'b0) break;
                cnt++;
            end
            check($sformatf("speed%0d low width", v), 32'(cnt), 32'(sv[v].width));
        end

        @(negedge clock);
        reset = 1'b1;
        speed = 2'b00;
        tick_n(3);
        reset = 1'b0;
        tick_n(5);

        // Transmitter vectors
        for (int v = 0; v < 4; v++) begin
            @(negedge clock);
            if (tv[v].is_id) id = 1'b1;
            else begin
                write = 1'b1;
                wrdata = tv[v].word;
                disabledGroups = tv[v].dis;
            end
            @(negedge clock);
            id = 1'b0;
            write = 1'b0;
            check($sformatf("tx%0d busy after accept", v), 32'(busy), 32'd1);
            fork
                begin
                    for (int k = 0; k < tv[v].n; k++) begin
                        uart_recv(1, 400, rb, rok);
                        check($sformatf("tx%0d byte%0d framed", v, k), 32'(rok), 32'd1);
                        check($sformatf("tx%0d byte%0d value", v, k), 32'(rb), 32'(tv[v].exp[8*k +: 8]));
                    end
                end
                begin
                    if (tv[v].poke) begin
                        tick_n(30);
                        wrdata = 32'hDEADBEEF;
                        disabledGroups = 4'b0000;
                        write = 1'b1;
                        tick_n(1);
                        write = 1'b0;
                    end
                end
            join
            check($sformatf("tx%0d busy in last stop", v), 32'(busy), 32'd1);
            tick_n(10);
            check($sformatf("tx%0d busy released", v), 32'(busy), 32'd0);
            if (tv[v].poke) begin
                uart_recv(1, 300, rb, rok);
                check("write while busy ignored", 32'(rok), 32'd0);
            end
        end

        // All groups disabled: one-cycle busy, tx idle
        @(negedge clock);
        write = 1'b1;
        wrdata = 32'hFFFFFFFF;
        disabledGroups = 4'b1111;
        @(negedge clock);
        write = 1'b0;
        cnt = 0;
        base = 0;
        for (int i = 0; i < 41; i++) begin
            if (busy === 1'b1) cnt++;
            if (tx !== 1'b1) base++;
            @(negedge clock);
        end
        check("all disabled busy cycles", 32'(cnt), 32'd1);
        check("all disabled tx low cycles", 32'(base), 32'd0);

        // Flow control
        @(negedge clock);
        write = 1'b1;
        wrdata = 32'h44332211;
        disabledGroups = 4'b0000;
        @(negedge clock);
        write = 1'b0;
        uart_recv(1, 100, rb, rok);
        check("fc byte0", 32'(rb), 32'h11);
        fork
            uart_recv(1, 100, rb, rok);
            begin
                tick_n(60);
                xoff = 1'b1;
                tick_n(1);
                xoff = 1'b0;
            end
        join
        check("fc byte1 framed", 32'(rok), 32'd1);
        check("fc byte1", 32'(rb), 32'h22);
        uart_recv(1, 300, rb, rok);
        check("fc paused no start", 32'(rok), 32'd0);
        check("fc paused busy", 32'(busy), 32'd1);
        xon = 1'b1;
        tick_n(1);
        xon = 1'b0;
        uart_recv(1, 100, rb, rok);
        check("fc byte2", 32'(rb), 32'h33);
        uart_recv(1, 100, rb, rok);
        check("fc byte3", 32'(rb), 32'h44);
        tick_n(10);
        check("fc busy released", 32'(busy), 32'd0);

        // Receiver vectors
        prev_op = 8'h00;
        for (int v = 0; v < 4; v++) begin
            base = exec_cnt;
            for (int k = 0; k < rv[v].n; k++) begin
                uart_send(rv[v].bytes[8*k +: 8], 1'b1);
                tick_n(4);
                if (k < rv[v].n - 1) begin
                    check($sformatf("rx%0d no early execute b%0d", v, k), 32'(exec_cnt - base), 32'd0);
                    check($sformatf("rx%0d op held b%0d", v, k), 32'(op), 32'(prev_op));
                end
            end
            check($sformatf("rx%0d execute count", v), 32'(exec_cnt - base), 32'd1);
            check($sformatf("rx%0d op", v), 32'(op), 32'(rv[v].op));
            check($sformatf("rx%0d data", v), data, rv[v].data);
            prev_op = rv[v].op;
            tick_n(8);
        end

        // Glitch on rx must not produce a byte
        base = exec_cnt;
        @(negedge clock);
        rx = 1'b0;
        tick_n(4);
        rx = 1'b1;
        tick_n(200);
        check("glitch no execute", 32'(exec_cnt - base), 32'd0);
        uart_send(8'h05, 1'b1);
        tick_n(4);
        check("after glitch execute", 32'(exec_cnt - base), 32'd1);
        check("after glitch op", 32'(op), 32'h05);

        // Framing error discards a partial long command
        base = exec_cnt;
        uart_send(8'h80, 1'b1);
        uart_send(8'h11, 1'b1);
        uart_send(8'h81, 1'b0);
        tick_n(20);
        check("framing no execute", 32'(exec_cnt - base), 32'd0);
        uart_send(8'h02, 1'b1);
        tick_n(4);
        check("after framing execute", 32'(exec_cnt - base), 32'd1);
        check("after framing op", 32'(op), 32'h02);
        check("after framing data", data, 32'h00000000);

        // Reset mid-frame aborts the transmission
        @(negedge clock);
        write = 1'b1;
        wrdata = 32'hFFFFFF00;
        disabledGroups = 4'b1110;
        @(negedge clock);
        write = 1'b0;
        uart_recv(1, 100, rb, rok);
        check("pre-abort byte", 32'(rb), 32'h00);
        @(negedge clock);
        write = 1'b1;
        @(negedge clock);
        write = 1'b0;
        tick_n(40);
        reset = 1'b1;
        tick_n(1);
        check("abort tx", 32'(tx), 32'd1);
        check("abort busy", 32'(busy), 32'd0);
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (tx !== 1'b1) cnt++;
        end
        check("abort tx stays idle", 32'(cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
